// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Brief    : Opcode/handshake inputs and control strobes of the control unit.
// Revision : 1.0
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [6:0]       opcode;
    logic             mem_ready;
    logic             pc_write;
    logic             ir_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
    logic             link_sel;
    logic [1:0]       ALU_src_a;
    logic [1:0]       ALU_src_b;
    logic [1:0]       ALU_op;
    logic             reg_write;
    logic             branch;
    logic             illegal;
    logic             mem_err;
    logic [3:0]       state;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output opcode, mem_ready,
        input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               link_sel, ALU_src_a, ALU_src_b, ALU_op, reg_write, branch,
               illegal, mem_err, state, instr_count
    );

    modport slave (
        input  opcode, mem_ready,
        output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
               link_sel, ALU_src_a, ALU_src_b, ALU_op, reg_write, branch,
               illegal, mem_err, state, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Multicycle CPU control FSM with memory timeout trap and retired-
//            instruction counter. Macro JAL_EN adds the JAL state.
// Revision : 1.0
// ============================================================================
module multicycle_control_unit #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input wire                     clk,
    input wire                     rst_n,
    multicycle_control_unit_if.slave bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
`ifdef JAL_EN
        S_JAL      = 4'd10,
`endif
        S_ERROR    = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       link_sel;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       branch;
    } ctrl_t;

    localparam logic [6:0] c_OP_R   = 7'b0110011;
    localparam logic [6:0] c_OP_I   = 7'b0010011;
    localparam logic [6:0] c_OP_LW  = 7'b0000011;
    localparam logic [6:0] c_OP_SW  = 7'b0100011;
    localparam logic [6:0] c_OP_BR  = 7'b1100011;
`ifdef JAL_EN
    localparam logic [6:0] c_OP_JAL = 7'b1101111;
`endif
    localparam int          c_TW        = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_TW-1:0] c_WAIT_LAST = c_TW'(MEM_TIMEOUT - 1);

    state_t           r_state;
    ctrl_t            r_ctrl;
    logic [6:0]       r_opcode;
    logic [c_TW-1:0]  r_wait;
    logic [CNT_W-1:0] r_count;
    logic             r_mem_err;
    logic             r_illegal;

    state_t w_next;
    logic   w_wait_state;
    logic   w_timeout;
    logic   w_retire;
    logic   w_fetch_go;

    // Strobe pattern for a given state; registered against the next state.
    function automatic ctrl_t f_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_read = 1'b1; c.src_b = 2'b01; end
            S_DECODE:   c.src_b = 2'b10;
            S_EXEC_R:   begin c.src_a = 2'b01; c.alu_op = 2'b10; end
            S_EXEC_I:   begin c.src_a = 2'b01; c.src_b = 2'b10; c.alu_op = 2'b10; end
            S_MEM_ADDR: begin c.src_a = 2'b01; c.src_b = 2'b10; end
            S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_WB_ALU:   c.reg_write = 1'b1;
            S_WB_MEM:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_BRANCH:   begin c.src_a = 2'b01; c.alu_op = 2'b01; c.branch = 1'b1; end
`ifdef JAL_EN
            S_JAL: begin
                c.pc_write = 1'b1; c.src_a = 2'b10; c.src_b = 2'b10;
                c.reg_write = 1'b1; c.link_sel = 1'b1;
            end
`endif
            default:    c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                       (r_state == S_MEM_WR);
        w_timeout    = w_wait_state && !bus.mem_ready && (r_wait == c_WAIT_LAST);
        w_next       = r_state;
        case (r_state)
            S_FETCH:    if (bus.mem_ready) w_next = S_DECODE;
                        else if (w_timeout) w_next = S_ERROR;
            S_DECODE: begin
                case (bus.opcode)
                    c_OP_R:           w_next = S_EXEC_R;
                    c_OP_I:           w_next = S_EXEC_I;
                    c_OP_LW, c_OP_SW: w_next = S_MEM_ADDR;
                    c_OP_BR:          w_next = S_BRANCH;
`ifdef JAL_EN
                    c_OP_JAL:         w_next = S_JAL;
`endif
                    default:          w_next = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
            S_MEM_ADDR: w_next = (r_opcode == c_OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) w_next = S_WB_MEM;
                        else if (w_timeout) w_next = S_ERROR;
            S_MEM_WR:   if (bus.mem_ready) w_next = S_FETCH;
                        else if (w_timeout) w_next = S_ERROR;
            S_WB_ALU, S_WB_MEM, S_BRANCH: w_next = S_FETCH;
`ifdef JAL_EN
            S_JAL:      w_next = S_FETCH;
`endif
            S_ERROR:    w_next = S_ERROR;
            default:    w_next = S_FETCH;
        endcase
        w_retire = (w_next == S_FETCH) &&
                   ((r_state == S_WB_ALU) || (r_state == S_WB_MEM) ||
`ifdef JAL_EN
                    (r_state == S_JAL) ||
`endif
                    (r_state == S_MEM_WR) || (r_state == S_BRANCH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ctrl    <= f_decode(S_FETCH);
            r_opcode  <= '0;
            r_wait    <= '0;
            r_count   <= '0;
            r_mem_err <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ctrl    <= f_decode(w_next);
            if (r_state == S_DECODE)
                r_opcode <= bus.opcode;
            if (w_next != r_state)
                r_wait <= '0;
            else if (w_wait_state && !bus.mem_ready)
                r_wait <= r_wait + 1'b1;
            if (w_retire)
                r_count <= r_count + 1'b1;
            // Only an unsupported opcode sends DECODE straight back to FETCH.
            r_illegal <= (r_state == S_DECODE) && (w_next == S_FETCH);
            if (w_next == S_ERROR)
                r_mem_err <= 1'b1;
        end
    end

    // Gated by rst_n so no PC/IR update is seen while reset is held.
    assign w_fetch_go      = rst_n && (r_state == S_FETCH) && bus.mem_ready;

    assign bus.pc_write    = w_fetch_go | r_ctrl.pc_write;
    assign bus.ir_write    = w_fetch_go;
    assign bus.i_or_d      = r_ctrl.i_or_d;
    assign bus.mem_read    = r_ctrl.mem_read;
    assign bus.mem_write   = r_ctrl.mem_write;
    assign bus.mem_to_reg  = r_ctrl.mem_to_reg;
    assign bus.link_sel    = r_ctrl.link_sel;
    assign bus.ALU_src_a   = r_ctrl.src_a;
    assign bus.ALU_src_b   = r_ctrl.src_b;
    assign bus.ALU_op      = r_ctrl.alu_op;
    assign bus.reg_write   = r_ctrl.reg_write;
    assign bus.branch      = r_ctrl.branch;
    assign bus.illegal     = r_illegal;
    assign bus.mem_err     = r_mem_err;
    assign bus.state       = r_state;
    assign bus.instr_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Directed self-checking bench for multicycle_control_unit.
// Revision : 1.0
// ============================================================================
module tb_multicycle_control_unit;

    localparam int TB_CNT_W = 4;   // narrow counter keeps the wrap check short
    localparam logic [6:0] OP_ADD = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   exp_count = 0;

    multicycle_control_unit_if #(.CNT_W(TB_CNT_W)) bus ();

    multicycle_control_unit #(
        .MEM_TIMEOUT (15),
        .CNT_W       (TB_CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic t_check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic t_beq();
        bus.opcode    = OP_BEQ;
        bus.mem_ready = 1'b1;
        tick(); tick(); tick();
        exp_count = (exp_count + 1) % (1 << TB_CNT_W);
    endtask

    initial begin
        bus.opcode    = 7'd0;
        bus.mem_ready = 1'b1;
        rst_n         = 1'b0;
        tick(); tick();
        t_check("rst_state",    32'(bus.state), 0);
        t_check("rst_mem_read", 32'(bus.mem_read), 1);
        t_check("rst_i_or_d",   32'(bus.i_or_d), 0);
        t_check("rst_pc_write", 32'(bus.pc_write), 0);
        t_check("rst_ir_write", 32'(bus.ir_write), 0);
        t_check("rst_reg_write",32'(bus.reg_write), 0);
        t_check("rst_count",    32'(bus.instr_count), 0);
        t_check("rst_mem_err",  32'(bus.mem_err), 0);
        t_check("rst_illegal",  32'(bus.illegal), 0);
        rst_n = 1'b1;
        #1;
        t_check("fetch_pc_write", 32'(bus.pc_write), 1);
        t_check("fetch_ir_write", 32'(bus.ir_write), 1);
        t_check("fetch_src_b",    32'(bus.ALU_src_b), 1);

        // add: 0,1,2,7,0
        bus.opcode = OP_ADD;
        tick(); t_check("add_s1", 32'(bus.state), 1);
        t_check("dec_src_b", 32'(bus.ALU_src_b), 2);
        tick(); t_check("add_s2", 32'(bus.state), 2);
        t_check("execr_alu_op", 32'(bus.ALU_op), 2);
        t_check("execr_src_a",  32'(bus.ALU_src_a), 1);
        tick(); t_check("add_s7", 32'(bus.state), 7);
        t_check("wb_reg_write", 32'(bus.reg_write), 1);
        t_check("wb_mem_to_reg",32'(bus.mem_to_reg), 0);
        tick(); t_check("add_s0", 32'(bus.state), 0);
        exp_count = 1;
        t_check("add_count", 32'(bus.instr_count), 32'(exp_count));

        // lw with three not-ready cycles in MEM_RD
        bus.opcode = OP_LW;
        tick(); t_check("lw_s1", 32'(bus.state), 1);
        tick(); t_check("lw_s4", 32'(bus.state), 4);
        t_check("addr_src_b", 32'(bus.ALU_src_b), 2);
        bus.mem_ready = 1'b0;
        tick(); t_check("lw_s5", 32'(bus.state), 5);
        t_check("rd_mem_read", 32'(bus.mem_read), 1);
        t_check("rd_i_or_d",   32'(bus.i_or_d), 1);
        for (int i = 0; i < 3; i++) begin
            tick(); t_check("lw_hold5", 32'(bus.state), 5);
        end
        bus.mem_ready = 1'b1;
        tick(); t_check("lw_s8", 32'(bus.state), 8);
        t_check("wbm_mem_to_reg", 32'(bus.mem_to_reg), 1);
        t_check("wbm_reg_write",  32'(bus.reg_write), 1);
        tick(); t_check("lw_s0", 32'(bus.state), 0);
        exp_count++;
        t_check("lw_count", 32'(bus.instr_count), 32'(exp_count));

        // sw: 0,1,4,6,0
        bus.opcode = OP_SW;
        tick(); tick(); tick();
        t_check("sw_s6", 32'(bus.state), 6);
        t_check("wr_mem_write", 32'(bus.mem_write), 1);
        t_check("wr_mem_read",  32'(bus.mem_read), 0);
        t_check("wr_i_or_d",    32'(bus.i_or_d), 1);
        tick(); t_check("sw_s0", 32'(bus.state), 0);
        exp_count++;
        t_check("sw_count", 32'(bus.instr_count), 32'(exp_count));

        // illegal opcode: one-cycle pulse, not counted
        bus.opcode = OP_BAD;
        tick(); t_check("bad_s1", 32'(bus.state), 1);
        bus.mem_ready = 1'b0;
        tick(); t_check("bad_s0", 32'(bus.state), 0);
        t_check("bad_illegal_hi", 32'(bus.illegal), 1);
        tick(); t_check("bad_illegal_lo", 32'(bus.illegal), 0);
        t_check("bad_count", 32'(bus.instr_count), 32'(exp_count));
        bus.mem_ready = 1'b1;

        // beq
        bus.opcode = OP_BEQ;
        tick(); tick();
        t_check("beq_s9",     32'(bus.state), 9);
        t_check("beq_branch", 32'(bus.branch), 1);
        t_check("beq_alu_op", 32'(bus.ALU_op), 1);
        t_check("beq_src_b",  32'(bus.ALU_src_b), 0);
        tick(); t_check("beq_s0", 32'(bus.state), 0);
        exp_count++;
        t_check("beq_count", 32'(bus.instr_count), 32'(exp_count));

        // jal
        bus.opcode = OP_JAL;
        tick(); tick();
`ifdef JAL_EN
        t_check("jal_s10",      32'(bus.state), 10);
        t_check("jal_link_sel", 32'(bus.link_sel), 1);
        t_check("jal_pc_write", 32'(bus.pc_write), 1);
        t_check("jal_reg_write",32'(bus.reg_write), 1);
        t_check("jal_src_a",    32'(bus.ALU_src_a), 2);
        tick(); t_check("jal_s0", 32'(bus.state), 0);
        exp_count++;
`else
        t_check("jal_s0",       32'(bus.state), 0);
        t_check("jal_illegal",  32'(bus.illegal), 1);
        t_check("jal_link_sel", 32'(bus.link_sel), 0);
`endif
        t_check("jal_count", 32'(bus.instr_count), 32'(exp_count));

        // counter wrap
        while (exp_count != 15) t_beq();
        t_check("cnt_max", 32'(bus.instr_count), 15);
        t_beq();
        t_check("cnt_wrap", 32'(bus.instr_count), 0);

        // mem_ready on the timeout cycle wins
        bus.opcode    = OP_ADD;
        bus.mem_ready = 1'b0;
        repeat (14) tick();
        t_check("win_hold", 32'(bus.state), 0);
        bus.mem_ready = 1'b1;
        tick(); t_check("win_s1", 32'(bus.state), 1);
        t_check("win_mem_err", 32'(bus.mem_err), 0);
        tick(); tick(); tick();
        exp_count++;
        t_check("win_count", 32'(bus.instr_count), 32'(exp_count));

        // fetch timeout traps to ERROR
        bus.mem_ready = 1'b0;
        repeat (14) tick();
        t_check("to_hold", 32'(bus.state), 0);
        tick(); t_check("to_s15", 32'(bus.state), 15);
        t_check("to_mem_err",  32'(bus.mem_err), 1);
        t_check("to_mem_read", 32'(bus.mem_read), 0);
        bus.mem_ready = 1'b1;
        repeat (3) tick();
        t_check("err_stuck",   32'(bus.state), 15);
        t_check("err_sticky",  32'(bus.mem_err), 1);
        t_check("err_pc_write",32'(bus.pc_write), 0);
        rst_n = 1'b0;
        #1;
        t_check("err_rst_state",   32'(bus.state), 0);
        t_check("err_rst_mem_err", 32'(bus.mem_err), 0);
        tick();
        rst_n = 1'b1;
        exp_count = 0;

        // async reset in MEM_RD
        t_beq();
        t_check("pre_rst_count", 32'(bus.instr_count), 32'(exp_count));
        bus.opcode = OP_LW;
        tick(); tick();
        bus.mem_ready = 1'b0;
        tick(); t_check("rd_before_rst", 32'(bus.state), 5);
        #2 rst_n = 1'b0;
        #1;
        t_check("async_rst_state", 32'(bus.state), 0);
        t_check("async_rst_count", 32'(bus.instr_count), 0);
        t_check("async_rst_i_or_d",32'(bus.i_or_d), 0);
        tick();
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
